// File: rtl/exu_lsu.sv
// -----------------------------------------------------------------------------
// exu_lsu -- multi-cycle load/store unit for the NPC execute stage.
//
// Takes one memory op per transaction over an in_valid/in_ready handshake,
// issues it on a req/gnt/rvalid memory port, and returns the result over an
// out_valid/out_ready handshake. Stores get byte-lane strobes and lane-shifted
// data; loads get their lane extracted and sign- or zero-extended to XLEN.
//
// Parameters:
//   XLEN        datapath width, 32 or 64
//   ADDR_WIDTH  memory address width
//   STRB_WIDTH  XLEN/8, derived
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        op handshake
//   ls_load, ls_store        op kind (both set = store, neither = non-memory op)
//   ls_size, ls_unsigned     0=byte 1=half 2=word 3=dword; zero-extend loads
//   ls_addr, ls_wdata        effective address, store data
//   mem_req/mem_gnt          memory request handshake
//   mem_we, mem_addr         write flag, XLEN/8-aligned address
//   mem_wdata, mem_wstrb     lane-shifted store data, byte enables
//   mem_rvalid, mem_rdata    read data return
//   out_valid/out_ready      result handshake
//   out_rdata, out_err       extended load data (0 otherwise), access error
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned or illegal-size accesses
//                         issue no request and complete with out_err=1.
//                         When undefined, the offset is forced to size
//                         alignment and out_err stays 0.
// -----------------------------------------------------------------------------
module exu_lsu #(
    parameter  int XLEN       = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int STRB_WIDTH = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ls_load,
    input  logic                  ls_store,
    input  logic [1:0]            ls_size,
    input  logic                  ls_unsigned,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [XLEN-1:0]       ls_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_rdata,
    output logic                  out_err
);

    localparam int OFF_W = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic                    uns_q, uns_d;
    logic [1:0]              size_q, size_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [XLEN-1:0]         rdata_q, rdata_d;
    logic                    err_q, err_d;

    // Accept-side decode of the incoming op.
    logic                    size_illegal;
    logic [1:0]              size_eff;
    logic [3:0]              size_bytes;
    logic [OFF_W-1:0]        off_raw, off_mask, off_acc;
    logic [STRB_WIDTH-1:0]   lane_mask;
    logic                    is_mem;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                    misaligned;
`endif

    always_comb begin
        // A dword on a 32-bit datapath degrades to a word unless it traps.
        size_illegal = (XLEN == 32) && (ls_size == 2'd3);
        size_eff     = size_illegal ? 2'd2 : ls_size;
        size_bytes   = 4'd1 << size_eff;
        off_raw      = ls_addr[OFF_W-1:0];
        off_mask     = OFF_W'(size_bytes - 4'd1);
        is_mem       = ls_load | ls_store;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned   = (off_raw & off_mask) != '0;
        off_acc      = off_raw;
`else
        off_acc      = off_raw & ~off_mask;
`endif
        for (int i = 0; i < STRB_WIDTH; i++) begin
            lane_mask[i] = (i < int'(size_bytes));
        end
    end

    // Load extract: bring the addressed lane down to bit 0, then extend.
    logic [XLEN-1:0] rd_shift, rd_ext;
    logic            rd_sign;
    int              nbits;

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        nbits    = 8 << size_q;
        case (size_q)
            2'd0:    rd_sign = rd_shift[7];
            2'd1:    rd_sign = rd_shift[15];
            2'd2:    rd_sign = rd_shift[31];
            default: rd_sign = rd_shift[XLEN-1];
        endcase
        for (int i = 0; i < XLEN; i++) begin
            rd_ext[i] = (i < nbits) ? rd_shift[i] : (rd_sign & ~uns_q);
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    we_d    = ls_store;
                    uns_d   = ls_unsigned;
                    size_d  = size_eff;
                    off_d   = off_acc;
                    addr_d  = {ls_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wstrb_d = ls_store ? (lane_mask << off_acc) : '0;
                    wdata_d = ls_store ? (ls_wdata << {off_acc, 3'b000}) : '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = is_mem ? REQ : RESP;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_mem && (misaligned || size_illegal)) begin
                        we_d    = 1'b0;
                        wstrb_d = '0;
                        wdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            REQ: begin
                // mem_rvalid is deliberately not looked at here.
                if (mem_gnt) state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = rd_ext;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // All outputs come straight from state/registers: glitch-free and stable
    // for the whole REQ and RESP phases.
    assign in_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign out_valid = (state_q == RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: doc/exu_lsu.md
Name: exu_lsu

Overview:
- Parametrised multi-cycle load/store unit for the NPC execute stage.
- Supersedes the single-cycle combinational memory control.
- Accepts one memory op per transaction over a valid/ready handshake and drives a req/gnt/rvalid memory port.
- Generates byte-lane write strobes and shifted write data, and returns sign- or zero-extended load data.
- Supports XLEN 32 or 64 and byte/half/word/dword sizes.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- ADDR_WIDTH, 32, memory address width.
- STRB_WIDTH, XLEN/8, write-strobe width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept an op.
- ls_load  in  1  op is a load.
- ls_store  in  1  op is a store (load and store both set is treated as a store).
- ls_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- ls_unsigned  in  1  zero-extend the load result (lbu/lhu/lwu).
- ls_addr  in  ADDR_WIDTH  effective address (alu_result).
- ls_wdata  in  XLEN  store data (src2).
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_WIDTH  address aligned to XLEN/8 bytes.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  STRB_WIDTH  byte enables.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_rdata  out  XLEN  extended load data; 0 for stores and non-memory ops.
- out_err  out  1  misaligned or illegal access.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - mem_req, mem_we, out_valid, out_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, out_rdata = 0.
  - in_ready = 1 once rst is released.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op, address and data.
  - Load or store goes to REQ; an op with neither flag goes to RESP with out_rdata=0.
  - A misaligned op goes to RESP with out_err=1 (see Optional Feature).
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb come from registers and stay stable until mem_gnt.
  - On mem_gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - On mem_rvalid, capture the extended data into out_rdata and go to RESP.
  - mem_rvalid in the same cycle as mem_gnt is not allowed by the memory contract.
- RESP:
  - out_valid=1; out_rdata and out_err are held stable until out_ready, then IDLE.
  - in_ready=0 in every state except IDLE, so there is no new accept while the result is pending.
- Latency: in_valid accepted at cycle T gives mem_req at T+1; a store with gnt at T+1 gives out_valid at T+2.
- Lane math: off = addr[log2(STRB_WIDTH)-1:0].
  - mem_addr = addr with those bits cleared.
  - mem_wstrb = ((1<<(1<<size))-1) << off.
  - mem_wdata = ls_wdata << (8*off).
  - On loads mem_wstrb=0 and mem_wdata=0.
- Load extract: (mem_rdata >> 8*off) truncated to the access size, then sign-extended (ls_unsigned=0) or zero-extended to XLEN.
- size=3 with XLEN=32 is illegal: out_err=1 if the feature is enabled, otherwise it is executed as a word access.
- Reset mid-operation: immediate return to IDLE and mem_req drops. A late mem_rvalid or mem_gnt arriving in IDLE is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - An access with off not a multiple of the size (or an illegal size) issues no memory request.
  - It goes IDLE->RESP with out_err=1 and out_rdata=0, so out_valid is asserted the cycle after accept.
- Undefined:
  - The low address bits are forced to size alignment (off &= ~(size_bytes-1)) and the access proceeds.
  - out_err is tied 0.

Test Plan:
1. Store byte: XLEN=32, sb addr 0x80000003, wdata 0x123456AB, gnt 2 cycles after mem_req.
   - Required: mem_addr 0x80000000, wstrb 4'b1000, mem_wdata 0xAB000000, mem_we=1.
   - Required: out_valid exactly 1 cycle after gnt, out_rdata=0.
2. Byte loads: lb addr 0x80000002, rdata 0x00F00000, rvalid 3 cycles after gnt.
   - Required: out_rdata 0xFFFFFFF0.
   - Same access as lbu: out_rdata 0x000000F0.
   - mem_wstrb=0 throughout.
3. Misaligned half load: lh at 0x80000001.
   - With LSU_MISALIGN_TRAP_EN: mem_req never asserted, out_valid next cycle, out_err=1.
   - Without it: mem_addr 0x80000000; rdata 0x0000FF80 gives out_rdata 0xFFFFFF80.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
   - Required: out_rdata stable, in_ready=0, and in_valid pulses are not accepted.
   - Release out_ready: in_ready=1 the following cycle.
5. Reset mid-load: drop rst in WAIT, then send rvalid after release.
   - Required: all outputs at reset values and the stray rvalid is ignored.
   - A following lw at 0x80000004 with rdata 0xDEADBEEF returns 0xDEADBEEF.
6. XLEN=64: sd at 0x80000008 wdata 0x0123456789ABCDEF.
   - Required: wstrb 8'hFF.
   - Required: lw at 0x80000004 with rdata 0x89ABCDEF_00000000 gives out_rdata 0xFFFFFFFF89ABCDEF.
